// File: rtl/mem_op_unit.sv
// mem_op_unit: MRR/LDC/LDD/STD unit with register file, data memory and valid/ready command handshake.
// Define MEM_OP_ZERO_REG_EN to hardwire R0 to zero.
module mem_op_unit #(
    parameter int DATA_W    = 20,
    parameter int NUM_REGS  = 16,
    parameter int MEM_DEPTH = 256,
    parameter int MEM_LAT   = 2,
    localparam int REG_AW   = $clog2(NUM_REGS),
    localparam int MEM_AW   = $clog2(MEM_DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        opcode,
    input  logic [REG_AW-1:0] rd,
    input  logic [REG_AW-1:0] ro,
    input  logic [DATA_W-1:0] imm,
    output logic              done_valid,
    output logic              done_err,
    output logic [REG_AW-1:0] done_rd,
    output logic [DATA_W-1:0] done_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, WAIT = 2'd2;
    localparam logic [1:0] OP_LDC = 2'd1, OP_LDD = 2'd2, OP_STD = 2'd3;
    localparam int CNT_W = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
    localparam int CMP_W = DATA_W > 32 ? DATA_W : 32;
`ifdef MEM_OP_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        op_q;
    logic [REG_AW-1:0] rd_q, ro_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [DATA_W-1:0] src, addr, wr_val;
    logic [MEM_AW-1:0] idx;
    logic              in_range, err, finish, r0_drop, reg_we, mem_we;

    function automatic logic [DATA_W-1:0] rd_reg(input logic [REG_AW-1:0] i);
        return (ZERO_REG && i == '0) ? '0 : regs[i];
    endfunction

    // R is frozen while busy, so operands are re-read each cycle rather than latched
    always_comb begin
        src      = rd_reg(ro_q);
        addr     = rd_reg(op_q == OP_STD ? rd_q : ro_q);
        in_range = CMP_W'(addr) < CMP_W'(MEM_DEPTH);
        idx      = addr[MEM_AW-1:0];
        err      = op_q[1] && !in_range;
        finish   = (state == EXEC && (!op_q[1] || err)) || (state == WAIT && cnt == CNT_W'(MEM_LAT - 1));
        wr_val   = op_q == OP_LDC ? imm_q : op_q == OP_LDD ? mem[idx] : src;
        r0_drop  = ZERO_REG && rd_q == '0 && op_q != OP_STD;
        reg_we   = finish && !err && op_q != OP_STD && !r0_drop;
        mem_we   = finish && !err && op_q == OP_STD;
    end

    assign op_ready = state == IDLE;
    assign dbg_data = rd_reg(dbg_addr);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            ro_q       <= '0;
            imm_q      <= '0;
            done_valid <= 1'b0;
            done_err   <= 1'b0;
            done_rd    <= '0;
            done_data  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            state      <= state == IDLE ? (op_valid ? EXEC : IDLE) : finish ? IDLE : WAIT;
            cnt        <= state == WAIT ? cnt + 1'b1 : '0;
            done_valid <= finish;
            if (op_ready && op_valid) begin
                op_q  <= opcode;
                rd_q  <= rd;
                ro_q  <= ro;
                imm_q <= imm;
            end
            if (finish) begin
                done_err  <= err;
                done_rd   <= rd_q;
                done_data <= (err || r0_drop) ? '0 : wr_val;
            end
            if (reg_we) regs[rd_q] <= wr_val;
        end
    end

    always_ff @(posedge clock)
        if (mem_we) mem[idx] <= src;
endmodule

// File: tb/tb_mem_op_unit.sv
// tb_mem_op_unit: directed self-checking bench for mem_op_unit (default parameters).
module tb_mem_op_unit;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [1:0]  opcode = '0;
    logic [3:0]  rd = '0, ro = '0, dbg_addr = '0;
    logic [19:0] imm = '0;
    logic        done_valid, done_err;
    logic [3:0]  done_rd;
    logic [19:0] done_data, dbg_data;
    int checks = 0, failures = 0;
    int lat;
    logic rdy_after;
    logic [19:0] pre_dbg;

    localparam logic [1:0] MRR = 2'd0, LDC = 2'd1, LDD = 2'd2, STD = 2'd3;

    mem_op_unit dut (
        .clock(clock), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready),
        .opcode(opcode), .rd(rd), .ro(ro), .imm(imm),
        .done_valid(done_valid), .done_err(done_err), .done_rd(done_rd), .done_data(done_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clock = ~clock;

    // lat = edges from accept to done pulse (-1 on timeout); rdy_after/pre_dbg sampled just after accept
    task automatic do_op(input logic [1:0] op, input logic [3:0] r_d, input logic [3:0] r_o, input logic [19:0] im,
                         output int l, output logic r, output logic [19:0] p);
        int n = 0;
        while (!op_ready && n < 50) begin @(posedge clock); #1; n++; end
        checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL ready_timeout got=%b exp=1", op_ready); end
        opcode = op; rd = r_d; ro = r_o; imm = im; op_valid = 1'b1;
        @(posedge clock); #1;
        op_valid = 1'b0;
        r = op_ready;
        p = dbg_data;
        l = -1;
        for (int i = 1; i <= 20; i++) begin
            if (done_valid) break;
            @(posedge clock); #1;
            if (done_valid) l = i;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", op_ready); end
        checks++; if (done_valid !== 1'b0) begin failures++; $display("FAIL rst_done_valid got=%b exp=0", done_valid); end
        checks++; if (done_err !== 1'b0) begin failures++; $display("FAIL rst_done_err got=%b exp=0", done_err); end
        checks++; if (done_rd !== 4'd0) begin failures++; $display("FAIL rst_done_rd got=%h exp=0", done_rd); end
        checks++; if (done_data !== 20'd0) begin failures++; $display("FAIL rst_done_data got=%h exp=0", done_data); end
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i); #1;
            checks++; if (dbg_data !== 20'd0) begin failures++; $display("FAIL rst_reg%0d got=%h exp=0", i, dbg_data); end
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_ldc;
        dbg_addr = 4'd3;
        do_op(LDC, 4'd3, 4'd0, 20'h0ABCD, lat, rdy_after, pre_dbg);
        checks++; if (lat !== 1) begin failures++; $display("FAIL ldc_latency got=%0d exp=1", lat); end
        checks++; if (rdy_after !== 1'b0) begin failures++; $display("FAIL ldc_busy got=%b exp=0", rdy_after); end
        checks++; if (pre_dbg !== 20'd0) begin failures++; $display("FAIL ldc_prewrite got=%h exp=0", pre_dbg); end
        checks++; if (done_rd !== 4'd3) begin failures++; $display("FAIL ldc_rd got=%h exp=3", done_rd); end
        checks++; if (done_data !== 20'h0ABCD) begin failures++; $display("FAIL ldc_data got=%h exp=0abcd", done_data); end
        checks++; if (done_err !== 1'b0) begin failures++; $display("FAIL ldc_err got=%b exp=0", done_err); end
        checks++; if (dbg_data !== 20'h0ABCD) begin failures++; $display("FAIL ldc_dbg got=%h exp=0abcd", dbg_data); end
        checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL ldc_ready_back got=%b exp=1", op_ready); end
        @(posedge clock); #1;
        checks++; if (done_valid !== 1'b0) begin failures++; $display("FAIL ldc_pulse got=%b exp=0", done_valid); end
        checks++; if (done_data !== 20'h0ABCD) begin failures++; $display("FAIL ldc_hold got=%h exp=0abcd", done_data); end
    endtask

    task automatic test_back_to_back;
        do_op(LDC, 4'd1, 4'd0, 20'h12345, lat, rdy_after, pre_dbg);
        checks++; if (lat !== 1) begin failures++; $display("FAIL b2b_ldc_latency got=%0d exp=1", lat); end
        dbg_addr = 4'd2;
        do_op(MRR, 4'd2, 4'd1, 20'h0, lat, rdy_after, pre_dbg);
        checks++; if (lat !== 1) begin failures++; $display("FAIL mrr_latency got=%0d exp=1", lat); end
        checks++; if (rdy_after !== 1'b0) begin failures++; $display("FAIL mrr_busy got=%b exp=0", rdy_after); end
        checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL mrr_ready_back got=%b exp=1", op_ready); end
        checks++; if (pre_dbg !== 20'd0) begin failures++; $display("FAIL mrr_prewrite got=%h exp=0", pre_dbg); end
        checks++; if (done_data !== 20'h12345) begin failures++; $display("FAIL mrr_data got=%h exp=12345", done_data); end
        checks++; if (dbg_data !== 20'h12345) begin failures++; $display("FAIL mrr_dbg got=%h exp=12345", dbg_data); end
        do_op(MRR, 4'd2, 4'd2, 20'h0, lat, rdy_after, pre_dbg);
        checks++; if (dbg_data !== 20'h12345) begin failures++; $display("FAIL mrr_self got=%h exp=12345", dbg_data); end
    endtask

    task automatic test_std_ldd;
        do_op(LDC, 4'd4, 4'd0, 20'd10, lat, rdy_after, pre_dbg);
        do_op(LDC, 4'd5, 4'd0, 20'hFFFFF, lat, rdy_after, pre_dbg);
        do_op(STD, 4'd4, 4'd5, 20'h0, lat, rdy_after, pre_dbg);
        checks++; if (lat !== 3) begin failures++; $display("FAIL std_latency got=%0d exp=3", lat); end
        checks++; if (done_rd !== 4'd4) begin failures++; $display("FAIL std_rd got=%h exp=4", done_rd); end
        checks++; if (done_data !== 20'hFFFFF) begin failures++; $display("FAIL std_data got=%h exp=fffff", done_data); end
        checks++; if (done_err !== 1'b0) begin failures++; $display("FAIL std_err got=%b exp=0", done_err); end
        dbg_addr = 4'd6;
        do_op(LDD, 4'd6, 4'd4, 20'h0, lat, rdy_after, pre_dbg);
        checks++; if (lat !== 3) begin failures++; $display("FAIL ldd_latency got=%0d exp=3", lat); end
        checks++; if (pre_dbg !== 20'd0) begin failures++; $display("FAIL ldd_prewrite got=%h exp=0", pre_dbg); end
        checks++; if (done_data !== 20'hFFFFF) begin failures++; $display("FAIL ldd_data got=%h exp=fffff", done_data); end
        checks++; if (dbg_data !== 20'hFFFFF) begin failures++; $display("FAIL ldd_dbg got=%h exp=fffff", dbg_data); end
        @(posedge clock); #1;
        checks++; if (done_valid !== 1'b0) begin failures++; $display("FAIL ldd_pulse got=%b exp=0", done_valid); end
    endtask

    task automatic test_range;
        do_op(LDC, 4'd7, 4'd0, 20'd256, lat, rdy_after, pre_dbg);
        dbg_addr = 4'd8;
        do_op(LDD, 4'd8, 4'd7, 20'h0, lat, rdy_after, pre_dbg);
        checks++; if (lat !== 1) begin failures++; $display("FAIL oor_ldd_latency got=%0d exp=1", lat); end
        checks++; if (done_err !== 1'b1) begin failures++; $display("FAIL oor_ldd_err got=%b exp=1", done_err); end
        checks++; if (done_data !== 20'd0) begin failures++; $display("FAIL oor_ldd_data got=%h exp=0", done_data); end
        checks++; if (done_rd !== 4'd8) begin failures++; $display("FAIL oor_ldd_rd got=%h exp=8", done_rd); end
        checks++; if (dbg_data !== 20'd0) begin failures++; $display("FAIL oor_ldd_r8 got=%h exp=0", dbg_data); end
        do_op(STD, 4'd7, 4'd1, 20'h0, lat, rdy_after, pre_dbg);
        checks++; if (lat !== 1) begin failures++; $display("FAIL oor_std_latency got=%0d exp=1", lat); end
        checks++; if (done_err !== 1'b1) begin failures++; $display("FAIL oor_std_err got=%b exp=1", done_err); end
        do_op(LDC, 4'd7, 4'd0, 20'd255, lat, rdy_after, pre_dbg);
        do_op(STD, 4'd7, 4'd1, 20'h0, lat, rdy_after, pre_dbg);
        checks++; if (lat !== 3) begin failures++; $display("FAIL top_std_latency got=%0d exp=3", lat); end
        checks++; if (done_err !== 1'b0) begin failures++; $display("FAIL top_std_err got=%b exp=0", done_err); end
        do_op(LDD, 4'd8, 4'd7, 20'h0, lat, rdy_after, pre_dbg);
        checks++; if (done_data !== 20'h12345) begin failures++; $display("FAIL top_ldd_data got=%h exp=12345", done_data); end
        checks++; if (dbg_data !== 20'h12345) begin failures++; $display("FAIL top_ldd_r8 got=%h exp=12345", dbg_data); end
    endtask

    task automatic test_zero_reg;
        logic [19:0] exp_r0;
`ifdef MEM_OP_ZERO_REG_EN
        exp_r0 = 20'd0;
`else
        exp_r0 = 20'd5;
`endif
        dbg_addr = 4'd0;
        do_op(LDC, 4'd0, 4'd0, 20'd5, lat, rdy_after, pre_dbg);
        checks++; if (lat !== 1) begin failures++; $display("FAIL r0_latency got=%0d exp=1", lat); end
        checks++; if (done_rd !== 4'd0) begin failures++; $display("FAIL r0_rd got=%h exp=0", done_rd); end
        checks++; if (done_data !== exp_r0) begin failures++; $display("FAIL r0_data got=%h exp=%h", done_data, exp_r0); end
        checks++; if (dbg_data !== exp_r0) begin failures++; $display("FAIL r0_dbg got=%h exp=%h", dbg_data, exp_r0); end
    endtask

    task automatic test_reset_mid_op;
        do_op(LDC, 4'd10, 4'd0, 20'h00055, lat, rdy_after, pre_dbg);
        dbg_addr = 4'd10;
        opcode = STD; rd = 4'd4; ro = 4'd10; op_valid = 1'b1;
        @(posedge clock); #1;
        op_valid = 1'b0;
        @(posedge clock); #1;
        checks++; if (op_ready !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", op_ready); end
        reset_n = 1'b0;
        #1;
        checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", op_ready); end
        checks++; if (dbg_data !== 20'd0) begin failures++; $display("FAIL abort_r10 got=%h exp=0", dbg_data); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            checks++; if (done_valid !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%b exp=0", done_valid); end
        end
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i); #1;
            checks++; if (dbg_data !== 20'd0) begin failures++; $display("FAIL abort_reg%0d got=%h exp=0", i, dbg_data); end
        end
        @(negedge clock);
        reset_n = 1'b1;
        do_op(LDC, 4'd4, 4'd0, 20'd10, lat, rdy_after, pre_dbg);
        dbg_addr = 4'd6;
        do_op(LDD, 4'd6, 4'd4, 20'h0, lat, rdy_after, pre_dbg);
        checks++; if (lat !== 3) begin failures++; $display("FAIL abort_ldd_latency got=%0d exp=3", lat); end
        checks++; if (done_data !== 20'hFFFFF) begin failures++; $display("FAIL abort_mem_kept got=%h exp=fffff", done_data); end
        checks++; if (dbg_data !== 20'hFFFFF) begin failures++; $display("FAIL abort_r6 got=%h exp=fffff", dbg_data); end
    endtask

    initial begin
        test_reset;
        test_ldc;
        test_back_to_back;
        test_std_ldd;
        test_range;
        test_zero_reg;
        test_reset_mid_op;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
